tpu_frontend_stream: RTL

Parametrised next-generation TPU instruction front-end. It accepts a per-issue instruction stream from the MPU allocator over a valid/ready handshake and parses a header word plus NUM_ID_WORDS thread-ID words. It writes the following instructions into the TPU instruction buffer with explicit addresses and back-pressure, then holds the issue until the scalar unit terminates it. It adds over the previous front-end: multi-word thread IDs, buffer addressing/counting, stall instead of drop on full, overflow/nack abort with stream drain, and enable gating per issue.

---
 rtl/tpu_frontend_stream.sv | 112 +++++++++++
 1 files changed

// File: rtl/tpu_frontend_stream.sv
// tpu_frontend_stream: TPU instruction front-end that parses header and thread-ID words, then
// writes the following instructions into the instruction buffer with back-pressure, abort and drain.
module tpu_frontend_stream #(
   parameter int INSTR_W      = 32,
   parameter int ID_W         = 8,
   parameter int NUM_ID_WORDS = 2,
   parameter int DEPTH        = 16,
   parameter int ISSUE_W      = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         I_En_Exe,
   input  logic                         I_Req,
   input  logic [INSTR_W-1:0]           I_Instr,
   input  logic [ISSUE_W-1:0]           I_IssueNo,
   output logic                         O_Ready,
   input  logic                         I_Full,
   input  logic                         I_Nack,
   input  logic                         I_Term,
   output logic                         O_We,
   output logic [$clog2(DEPTH)-1:0]     O_Addr,
   output logic [INSTR_W-1:0]           O_Instr,
   output logic                         O_Wr_End,
   output logic [$clog2(DEPTH+1)-1:0]   O_Count,
   output logic [NUM_ID_WORDS*ID_W-1:0] O_ThreadID,
   output logic [ISSUE_W-1:0]           O_IssueNo,
   output logic                         O_Term,
   output logic                         O_Nack,
   output logic                         O_Busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(NUM_ID_WORDS+1);
   typedef enum logic [2:0] {IDLE, HDR, LOAD, DRAIN, WAIT_TERM} state_t;
   state_t state, state_nxt;
   logic [AW-1:0] wptr;
   logic [IW-1:0] idx;
   logic beat, v, hdr_beat, id_beat, abort, wr, wend, term;
   always_comb begin
      O_Ready = (state == IDLE)  ? I_En_Exe :
                (state == HDR)   ? 1'b1 :
                (state == LOAD)  ? ~I_Full :
                (state == DRAIN) ? 1'b1 : 1'b0;
      beat     = I_Req & O_Ready;
      v        = I_Instr[INSTR_W-1];
      hdr_beat = (state == IDLE) & beat & v;
      id_beat  = (state == HDR) & beat & v;
      // nack wins over everything in LOAD; overflow only when a real instruction arrives at a full count
      abort    = (state == LOAD) & (I_Nack | (beat & v & (O_Count == CW'(DEPTH))));
      wr       = (state == LOAD) & ~abort & beat & v;
      wend     = (state == LOAD) & ~I_Nack & ~I_Req & (O_Count != '0);
      term     = (state == WAIT_TERM) & I_Term;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = hdr_beat ? HDR : IDLE;
         HDR:       state_nxt = (id_beat && idx == IW'(NUM_ID_WORDS-1)) ? LOAD : HDR;
         LOAD:      state_nxt = abort ? DRAIN : wend ? WAIT_TERM : LOAD;
         DRAIN:     state_nxt = I_Req ? DRAIN : IDLE;
         WAIT_TERM: state_nxt = term ? IDLE : WAIT_TERM;
         default:   state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         O_We       <= 1'b0;
         O_Wr_End   <= 1'b0;
         O_Term     <= 1'b0;
         O_Nack     <= 1'b0;
         O_Addr     <= '0;
         O_Count    <= '0;
         O_Instr    <= '0;
         O_ThreadID <= '0;
         O_IssueNo  <= '0;
         wptr       <= '0;
         idx        <= '0;
      end else begin
         O_We     <= wr;
         O_Wr_End <= wend;
         O_Term   <= term;
         O_Nack   <= abort;
         if (hdr_beat) begin
            O_IssueNo  <= I_IssueNo;
            O_Count    <= '0;
            O_Addr     <= '0;
            O_ThreadID <= '0;
            wptr       <= '0;
            idx        <= '0;
         end
         if (id_beat) begin
            O_ThreadID[idx*ID_W +: ID_W] <= I_Instr[ID_W-1:0];
            idx <= idx + 1'b1;
         end
         if (wr) begin
            O_Instr <= I_Instr;
            O_Addr  <= wptr;
            wptr    <= wptr + 1'b1;
            O_Count <= O_Count + 1'b1;
         end
         if (abort) begin
            O_IssueNo  <= '0;
            O_ThreadID <= '0;
         end
      end
   end
   assign O_Busy = (state != IDLE);
endmodule
